// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: field widths,
// the invalid port code, transmitter states and the header packing rule.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << LEN_W;

  localparam logic [ADDR_W-1:0] PORT_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    PAYLOAD,
    PARITY
  } tx_state_t;

  // Header byte carries the payload length above the destination port.
  function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for one packet: 64 bytes, synchronous write and synchronous read.
// Contents are don't-care after reset, so the array carries no reset.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the 1x3 router: buffers a whole payload,
// then sends header, payload and parity while honouring the router's busy stall.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              pkt_valid,
  output logic              done,
  output logic              err
);

  tx_state_t         state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [DATA_W-1:0] parity;
  logic [DATA_W-1:0] first_byte;
  logic [DATA_W-1:0] rd_data;
  logic [LEN_W-1:0]  rd_addr;
  logic              wr_en;
  logic              last_idx;

  assign wr_en    = (state == LOAD) && pl_valid;
  assign last_idx = (idx == len_q - LEN_W'(1));

  // Keep buf[idx+1] in rd_data while buf[idx] is on the wire, so a transfer
  // edge can load the next byte directly. Byte 0 comes from first_byte because
  // a one-byte packet writes entry 0 on the same edge the header goes out.
  always_comb begin
    rd_addr = idx + LEN_W'(1);
    if (state == HDR && !busy) begin
      rd_addr = LEN_W'(1);
    end else if (state == PAYLOAD && !busy) begin
      rd_addr = idx + LEN_W'(2);
    end
  end

  router_tx_buf u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx),
    .wr_data (pl_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      pl_ready   <= 1'b0;
      tx_data    <= '0;
      pkt_valid  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      parity     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      idx        <= '0;
      first_byte <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_addr == PORT_INVALID || req_len == '0) begin
              err <= 1'b1;
            end else begin
              addr_q    <= req_addr;
              len_q     <= req_len;
              parity    <= pack_header(req_len, req_addr);
              idx       <= '0;
              req_ready <= 1'b0;
              pl_ready  <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (pl_valid) begin
            parity <= parity ^ pl_data;
            if (idx == '0) begin
              first_byte <= pl_data;
            end
            if (last_idx) begin
              idx       <= '0;
              pl_ready  <= 1'b0;
              tx_data   <= pack_header(len_q, addr_q);
              pkt_valid <= 1'b1;
              state     <= HDR;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        HDR: begin
          if (!busy) begin
            tx_data <= first_byte;
            state   <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            if (last_idx) begin
              tx_data   <= parity;
              pkt_valid <= 1'b0;
              state     <= PARITY;
            end else begin
              idx     <= idx + LEN_W'(1);
              tx_data <= rd_data;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            done      <= 1'b1;
            req_ready <= 1'b1;
            tx_data   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed and randomized bench for router_pkt_tx; the expected router byte
// stream is rebuilt from the packet contents and advanced on every busy=0 edge.
module tb_router_pkt_tx;
  import router_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              pl_valid;
  logic              pl_ready;
  logic [DATA_W-1:0] pl_data;
  logic              busy;
  logic [DATA_W-1:0] tx_data;
  logic              pkt_valid;
  logic              done;
  logic              err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pay [$];

  router_pkt_tx dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .busy      (busy),
    .tx_data   (tx_data),
    .pkt_valid (pkt_valid),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Sends one packet using the bytes in pay. busy_mode: 0 never busy,
  // 1 three busy cycles on the header, 2 alternating busy in payload, 3 random.
  // abort_at >= 0 stops driving once that stream byte is on the wire.
  task automatic apply_stimulus(input logic [1:0] addr, input int len, input int busy_mode,
                                input bit force_gap, input int abort_at);
    logic [7:0] exp_byte [$];
    logic [7:0] par;
    int loaded;
    int k;
    int iter;
    int hdr_busy;
    bit gap_done;
    bit toggle;
    bit v;
    bit b;

    exp_byte.push_back(8'(len * 4 + int'(addr)));
    par = exp_byte[0];
    for (int i = 0; i < len; i++) begin
      exp_byte.push_back(pay[i]);
      par = par ^ pay[i];
    end
    exp_byte.push_back(par);

    @(negedge clk);
    check_output("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = LEN_W'(len);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("req_ready_after_accept", req_ready, 0);
    check_output("err_on_valid_req", err, 0);

    loaded = 0;
    iter = 0;
    gap_done = 1'b0;
    while (loaded < len && iter < 20 * len + 50) begin
      check_output("pl_ready_load", pl_ready, 1);
      check_output("pkt_valid_load", pkt_valid, 0);
      if (force_gap && loaded == 1 && !gap_done) begin
        v = 1'b0;
        gap_done = 1'b1;
      end else if (force_gap) begin
        v = 1'b1;
      end else begin
        v = ($urandom_range(0, 3) != 0);
      end
      pl_valid = v;
      pl_data  = pay[loaded];
      @(negedge clk);
      if (v) loaded++;
      iter++;
    end
    pl_valid = 1'b0;
    check_output("load_complete", loaded, len);
    check_output("pl_ready_after_load", pl_ready, 0);

    k = 0;
    iter = 0;
    hdr_busy = 0;
    toggle = 1'b1;
    while (k < len + 2 && iter < 40 * len + 200) begin
      if (k == abort_at) break;
      check_output("tx_data", tx_data, exp_byte[k]);
      check_output("pkt_valid", pkt_valid, (k <= len) ? 1 : 0);
      check_output("done_early", done, 0);
      case (busy_mode)
        1: begin
          b = (k == 0 && hdr_busy < 3);
          if (b) hdr_busy++;
        end
        2: begin
          b = (k >= 1 && k <= len) ? toggle : 1'b0;
          if (k >= 1 && k <= len) toggle = ~toggle;
        end
        3: b = ($urandom_range(0, 2) == 0);
        default: b = 1'b0;
      endcase
      busy = b;
      @(negedge clk);
      if (!b) k++;
      iter++;
    end
    busy = 1'b0;
    if (abort_at >= 0) return;
    check_output("bytes_transferred", k, len + 2);
    check_output("done_pulse", done, 1);
    check_output("req_ready_after_done", req_ready, 1);
    check_output("pkt_valid_after_done", pkt_valid, 0);
    @(negedge clk);
    check_output("done_one_cycle", done, 0);
  endtask

  task automatic apply_invalid(input logic [1:0] addr, input logic [5:0] len);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("err_pulse", err, 1);
    check_output("req_ready_invalid", req_ready, 1);
    check_output("pl_ready_invalid", pl_ready, 0);
    check_output("pkt_valid_invalid", pkt_valid, 0);
    @(negedge clk);
    check_output("err_one_cycle", err, 0);
    check_output("pl_ready_stays_low", pl_ready, 0);
    check_output("req_ready_stays_high", req_ready, 1);
  endtask

  task automatic load_basic();
    pay.delete();
    pay.push_back(8'hA1);
    pay.push_back(8'hB2);
    pay.push_back(8'hC3);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_len = '0;
    pl_valid = 1'b0;
    pl_data = '0;
    busy = 1'b0;

    @(negedge clk);
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_pl_ready", pl_ready, 0);
    check_output("rst_tx_data", tx_data, 0);
    check_output("rst_pkt_valid", pkt_valid, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] basic packet");
    load_basic();
    apply_stimulus(2'd1, 3, 0, 1'b1, -1);

    $display("[TB] busy on header");
    apply_stimulus(2'd1, 3, 1, 1'b0, -1);

    $display("[TB] busy toggling in payload");
    apply_stimulus(2'd1, 3, 2, 1'b0, -1);

    $display("[TB] invalid requests");
    apply_invalid(2'd3, 6'd5);
    apply_invalid(2'd1, 6'd0);

    $display("[TB] maximum length");
    pay.delete();
    for (int i = 0; i < 63; i++) pay.push_back(8'hFF);
    apply_stimulus(2'd0, 63, 0, 1'b0, -1);

    $display("[TB] reset mid-payload");
    load_basic();
    apply_stimulus(2'd1, 3, 0, 1'b0, 2);
    #2 reset = 1'b1;
    #1;
    check_output("midrst_pkt_valid", pkt_valid, 0);
    check_output("midrst_tx_data", tx_data, 0);
    check_output("midrst_req_ready", req_ready, 1);
    check_output("midrst_pl_ready", pl_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(2'd1, 3, 0, 1'b1, -1);

    $display("[TB] random packets");
    for (int n = 0; n < 8; n++) begin
      int len;
      logic [1:0] addr;
      len  = $urandom_range(1, 63);
      addr = 2'($urandom_range(0, 2));
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      apply_stimulus(addr, len, 3, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Store-and-forward packet transmitter that drives the input side of the 1x3 router. It accepts a packet request (destination port and payload length), then buffers the full payload from a byte stream while accumulating parity. It then serialises header, payload and parity onto the router's `data_in`/`pkt_valid` interface, honouring the router FSM's `busy` back-pressure. It is the source end of the router packet protocol and serves both as a bench stimulus generator and as an upstream block in the system.

## Interface
- `DATA_W`, 8: byte width. Fixed by the packet format.
- `LEN_W`, 6: payload length field width. Maximum payload is 63 bytes.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: packet request valid.
- `req_ready` out 1: request accept. High only in IDLE.
- `req_addr` in 2: destination port 0..2. Value 3 is invalid.
- `req_len` in 6: payload byte count, 1..63. Value 0 is invalid.
- `pl_valid` in 1: payload byte valid.
- `pl_ready` out 1: payload accept. High only in LOAD.
- `pl_data` in 8: payload byte.
- `busy` in 1: router FSM busy. A byte transfers only on an edge where this is 0.
- `tx_data` out 8: byte to router `data_in`.
- `pkt_valid` out 1: router `pkt_valid`. High for header and payload, low for parity.
- `done` out 1: one-cycle pulse when the parity byte is accepted.
- `err` out 1: one-cycle pulse when a request is rejected.

## Operation
- **Header format:** `{req_len, req_addr}`, i.e. length in bits [7:2] and address in bits [1:0].
- **Parity:** XOR of the header and every payload byte, 8 bits wide. It accumulates during LOAD.
- **Request transfer:** occurs on an edge with `req_valid & req_ready`. The address and length are latched on that edge.
- **Payload transfer:** occurs on an edge with `pl_valid & pl_ready`. Each byte is written to buffer entry `idx`, and `idx` increments. Gaps in `pl_valid` are allowed.
- **Router transfer:** occurs on an edge where the transmitter is presenting a byte and `busy == 0`. While `busy == 1`, `tx_data` and `pkt_valid` hold unchanged. No byte is ever skipped or duplicated.
- **State machine:**
  - IDLE: `req_ready = 1`. On a request, go to LOAD. If the request is invalid (`req_addr == 3` or `req_len == 0`), pulse `err` and stay in IDLE; no payload is consumed.
  - LOAD: `pl_ready = 1`. After byte number `req_len` is written, go to HDR.
  - HDR: `tx_data` = header, `pkt_valid = 1`. On a router transfer, go to PAYLOAD with `idx = 0`.
  - PAYLOAD: `tx_data` = `buf[idx]`, `pkt_valid = 1`. Each router transfer increments `idx`. The transfer of the last byte goes to PARITY.
  - PARITY: `tx_data` = parity, `pkt_valid = 0`. On a router transfer, pulse `done` and go to IDLE.
- **Reset values:** `req_ready = 1`, `pl_ready = 0`, `tx_data = 0`, `pkt_valid = 0`, `done = 0`, `err = 0`, state IDLE, parity 0.
- **Reset mid-packet:** outputs return to reset values immediately. The router sees a truncated packet; recovery is the router's responsibility. Buffer contents are don't-care.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- **Request:** accepted at edge T. `req_ready` drops and `pl_ready` rises after edge T.
- **Invalid request:** `err` is high for the single cycle after edge T.
- **Load to send:** the last payload byte is written at edge L. The header is on `tx_data` with `pkt_valid = 1` after edge L, with zero idle cycles.
- **Router handover:** each byte appears the cycle after the previous byte's transfer edge. With `busy` held at 0, a packet of N bytes occupies N+2 consecutive cycles on the router interface.
- **Completion:** `done` and `req_ready` rise after the parity transfer edge. A new request can be accepted on the next edge.
- **Buffer read:** synchronous. The implementation prefetches `buf[idx+1]` so that `busy` stalls never introduce bubbles or stale data.

## Structure
- Shared package `router_pkg` holds:
  - `DATA_W`, `LEN_W`, `ADDR_W = 2`.
  - `PORT_INVALID = 2'b11`.
  - The `tx_state_t` enum: IDLE, LOAD, HDR, PAYLOAD, PARITY.
  - A header pack function.
- One sub-module, `router_tx_buf`: a 64x8 array with synchronous write and synchronous read. It has no reset.
- The FSM, counters and parity register live in `router_pkt_tx`.

## Test plan
- **Basic packet:** `addr = 1`, `len = 3`, payload A1 B2 C3 loaded with one `pl_valid` gap, `busy = 0` → `tx_data` sequence 0D, A1, B2, C3 with `pkt_valid = 1`, then DD with `pkt_valid = 0`, then `done` pulses once.
- **Busy on header:** `busy = 1` for 3 cycles while the header 0D is presented → 0D is held 4 cycles with `pkt_valid = 1`. Payload then proceeds with no skipped byte.
- **Busy toggling in payload:** `busy` alternates 1/0 during the payload → each byte appears exactly until its `busy = 0` edge. Count of transferred bytes is 3 and parity is DD.
- **Invalid requests:** `req_addr = 3` (then separately `req_len = 0`) → `err` pulses one cycle, `pl_ready` never rises, `pkt_valid` stays 0, `req_ready` stays 1.
- **Maximum length:** `addr = 0`, `len = 63`, all payload bytes FF → header FC, 63 bytes of FF, parity 03, `done` pulses.
- **Reset mid-payload:** `reset` asserted during PAYLOAD → `pkt_valid` and `tx_data` go to 0 without waiting for a clock edge, and `req_ready = 1`. After release, the basic packet above transmits correctly.
